// File: rtl/sw_debounce.sv
// Switch front end: a two-flop synchronizer and a per-bit debounce window for each slide switch.
// It drives clean levels, a one-cycle change pulse and a sticky change flag.
module sw_debounce #(
    parameter int WIDTH         = 24,
    parameter int STABLE_CYCLES = 500000,
    parameter int CNT_W         = $clog2(STABLE_CYCLES)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] sw_raw,
    output logic [WIDTH-1:0] sw,
    output logic             sw_changed,
    output logic             change_flag,
    input  logic             flag_clr
);

    localparam logic [CNT_W-1:0] LP_TC = CNT_W'(STABLE_CYCLES - 1);

    logic [WIDTH-1:0] r_s1;
    logic [WIDTH-1:0] r_s2;
    logic [WIDTH-1:0] r_sw;
    logic [CNT_W-1:0] r_cnt [WIDTH];
    logic             r_sw_changed;
    logic             r_change_flag;

    logic [WIDTH-1:0] w_upd;
    logic [WIDTH-1:0] w_sw_nxt;
    logic [CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic             w_any_upd;

    // A counter only advances while s2 disagrees with sw; any agreement restarts the window.
    always_comb begin
        w_upd     = '0;
        w_sw_nxt  = r_sw;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            if (r_s2[i] != r_sw[i]) begin
                if (r_cnt[i] == LP_TC) begin
                    w_upd[i]    = 1'b1;
                    w_sw_nxt[i] = r_s2[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + CNT_W'(1);
                end
            end
        end
        w_any_upd = |w_upd;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_sw          <= '0;
            r_sw_changed  <= 1'b0;
            r_change_flag <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1         <= sw_raw;
            r_s2         <= r_s1;
            r_sw         <= w_sw_nxt;
            r_sw_changed <= w_any_upd;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            // When a set and a clear land on the same edge, the set wins.
            if (w_any_upd) begin
                r_change_flag <= 1'b1;
            end else if (flag_clr) begin
                r_change_flag <= 1'b0;
            end
        end
    end

    assign sw          = r_sw;
    assign sw_changed  = r_sw_changed;
    assign change_flag = r_change_flag;

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with STABLE_CYCLES=4.
// A timestamp model of the debounce windows is checked every cycle, alongside hand-computed literals.
module tb_sw_debounce;

    localparam int W = 24;
    localparam int S = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] sw_raw;
    logic [W-1:0] sw;
    logic         sw_changed;
    logic         change_flag;
    logic         flag_clr;

    sw_debounce #(.WIDTH(W), .STABLE_CYCLES(S)) dut (
        .clk         (clk),
        .rst         (rst),
        .sw_raw      (sw_raw),
        .sw          (sw),
        .sw_changed  (sw_changed),
        .change_flag (change_flag),
        .flag_clr    (flag_clr)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int n_pulses = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Model: each bit remembers the edge at which its current disagreement with sw began.
    // The bit is accepted once that disagreement has been seen on S consecutive edges.
    logic [W-1:0] m_s1, m_s2, m_sw;
    logic         m_chg, m_flag;
    int           since [W];
    int           ecnt = 0;
    bit           started = 0;

    always @(posedge clk) begin
        logic any;
        ecnt++;
        started = 1;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_sw = '0; m_chg = 0; m_flag = 0;
            for (int i = 0; i < W; i++) since[i] = -1;
        end else begin
            logic [W-1:0] nsw;
            any = 0;
            nsw = m_sw;
            for (int i = 0; i < W; i++) begin
                if (m_s2[i] == m_sw[i]) since[i] = -1;
                else begin
                    if (since[i] < 0) since[i] = ecnt;
                    if (ecnt - since[i] == S - 1) begin
                        nsw[i] = m_s2[i];
                        since[i] = -1;
                        any = 1;
                    end
                end
            end
            m_sw   = nsw;
            m_chg  = any;
            m_flag = any ? 1'b1 : (flag_clr ? 1'b0 : m_flag);
            m_s2   = m_s1;
            m_s1   = sw_raw;
        end
    end

    always @(negedge clk) begin
        if (started) begin
            chk("model_sw", 32'(sw), 32'(m_sw));
            chk("model_sw_changed", 32'(sw_changed), 32'(m_chg));
            chk("model_change_flag", 32'(change_flag), 32'(m_flag));
            if (sw_changed === 1'b1) n_pulses++;
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int p0;
        rst = 1; sw_raw = 24'hFFFFFF; flag_clr = 0;
        // Reset with all switches high.
        step(3);
        chk("rst_sw", 32'(sw), 32'h0);
        chk("rst_chg", 32'(sw_changed), 32'h0);
        chk("rst_flag", 32'(change_flag), 32'h0);
        rst = 0;
        step(5);
        chk("post_rst_sw_early", 32'(sw), 32'h0);
        step(1);
        chk("post_rst_sw", 32'(sw), 32'hFFFFFF);
        chk("post_rst_pulse", 32'(sw_changed), 32'h1);
        step(1);
        chk("post_rst_pulse_end", 32'(sw_changed), 32'h0);
        chk("post_rst_flag", 32'(change_flag), 32'h1);

        sw_raw = 0; step(8);
        chk("all_low", 32'(sw), 32'h0);
        flag_clr = 1; step(1); flag_clr = 0;
        chk("flag_cleared", 32'(change_flag), 32'h0);

        // Clean press on bit 0.
        sw_raw = 24'h000001;
        step(5);
        chk("press_before", 32'(sw), 32'h0);
        step(1);
        chk("press_sw", 32'(sw), 32'h000001);
        chk("press_pulse", 32'(sw_changed), 32'h1);
        step(1);
        chk("press_pulse_once", 32'(sw_changed), 32'h0);
        step(3);
        chk("press_flag_sticky", 32'(change_flag), 32'h1);

        // Bounce on bit 3: 3 high, 1 low, then held high.
        sw_raw[3] = 1; step(3);
        sw_raw[3] = 0; step(1);
        sw_raw[3] = 1;
        step(5);
        chk("bounce_hold", 32'(sw[3]), 32'h0);
        step(1);
        chk("bounce_sw3", 32'(sw[3]), 32'h1);
        chk("bounce_pulse", 32'(sw_changed), 32'h1);

        // Short glitch on bit 7.
        sw_raw[7] = 1; step(2);
        sw_raw[7] = 0; step(8);
        chk("glitch_sw7", 32'(sw[7]), 32'h0);
        chk("glitch_cnt7", 32'(dut.r_cnt[7]), 32'h0);

        // Simultaneous update of many bits.
        sw_raw = 0; step(8);
        p0 = n_pulses;
        sw_raw = 24'hA5A5A5;
        step(5);
        chk("simul_before", 32'(sw), 32'h0);
        step(1);
        chk("simul_sw", 32'(sw), 32'hA5A5A5);
        step(4);
        chk("simul_one_pulse", 32'(n_pulses - p0), 32'h1);

        // Staggered bits give separate pulses.
        sw_raw = 0; step(8);
        p0 = n_pulses;
        sw_raw[0] = 1; step(2);
        sw_raw[1] = 1; step(10);
        chk("stagger_sw", 32'(sw), 32'h000003);
        chk("stagger_two_pulses", 32'(n_pulses - p0), 32'h2);

        // Clear racing a set: set wins.
        flag_clr = 1; step(1); flag_clr = 0;
        chk("race_pre_clear", 32'(change_flag), 32'h0);
        sw_raw[5] = 1;
        step(5);
        flag_clr = 1; step(1); flag_clr = 0;
        chk("race_set_wins", 32'(change_flag), 32'h1);
        flag_clr = 1; step(1); flag_clr = 0;
        chk("plain_clear", 32'(change_flag), 32'h0);

        // Reset mid-count aborts, then the high switch is re-debounced.
        sw_raw = 24'h000400; step(3);
        rst = 1; step(1); rst = 0;
        chk("midrst_sw", 32'(sw), 32'h0);
        step(4);
        chk("midrst_hold", 32'(sw), 32'h0);
        step(2);
        chk("midrst_redebounce", 32'(sw), 32'h000400);

        step(2);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/sw_debounce.md
# sw_debounce

Synchronizes and debounces the 24 on-board slide switches before they reach the switch MMIO read port at 0xFFFFF070. The block sits directly upstream of the switch read register. Its `sw` output is that register's `sw[23:0]` input, so the CPU only ever reads clean, metastability-free, bounce-free switch levels. It also produces a one-cycle change pulse and a sticky change flag for software polling.

## Interface
Parameters:
- `WIDTH`, default 24: number of switch bits.
- `STABLE_CYCLES`, default 500000: consecutive cycles a synchronized bit must differ from its debounced value before it is accepted. Legal range is 2 to 2^24.
- `CNT_W`, default `$clog2(STABLE_CYCLES)`: per-bit counter width. It is derived and must not be overridden.

Ports:
- `clk` input 1: system clock, shared with the CPU and the switch register.
- `rst` input 1: reset. One clock; reset is synchronous and active-high.
- `sw_raw` input WIDTH: asynchronous pad levels from the switches.
- `sw` output WIDTH: debounced switch levels, registered. Feeds the switch read register.
- `sw_changed` output 1: one-cycle pulse in the cycle any bit of `sw` takes a new value.
- `change_flag` output 1: sticky indication that `sw` has changed since the last clear.
- `flag_clr` input 1: synchronous clear of `change_flag`.

## Operation
- Each bit passes through a two-flop synchronizer. Call the flop stages `s1` and `s2`; `s2` is the only stage used downstream. Nothing reads `sw_raw` or `s1` combinationally.
- Each bit has its own `CNT_W`-bit counter `cnt[i]` and its own debounced register `sw[i]`. Bits are fully independent.
- The per-bit update rule at each `clk` edge, in priority order:
  - If `s2[i] == sw[i]`: `cnt[i] <= 0`. This covers a glitch shorter than the window, which is discarded.
  - Else, if `cnt[i] == STABLE_CYCLES-1`: `sw[i] <= s2[i]` and `cnt[i] <= 0`.
  - Else: `cnt[i] <= cnt[i] + 1`.
- Counters never wrap. The compare at `STABLE_CYCLES-1` always fires before overflow.
- `sw_changed` is registered. It is 1 in exactly the cycle following any edge at which at least one `sw[i]` was updated, so it is coincident with the new `sw` value. If several bits update on the same edge, only one pulse is produced.
- `change_flag` is set by the same condition that produces `sw_changed` and cleared by `flag_clr`. If a set and a clear occur on the same edge, the set wins and the flag stays 1.
- The block has no bus interface. Address decode stays in the switch read register.

## Timing
- Reset values: `s1`, `s2`, `sw`, and all `cnt` are 0; `sw_changed` and `change_flag` are 0. Reset has priority over every other action.
- Reset applied mid-count aborts the count. After reset is released, a switch that is already high is re-debounced from 0 and appears after the full latency.
- Latency, taking edge 0 as the first edge that samples a new stable `sw_raw` level:
  - `s2` changes after edge 1.
  - `sw` changes after edge `STABLE_CYCLES+1`.
  - `sw_changed` is high for the single cycle after that edge.
- A bounce in which `s2` reverts for even one cycle restarts the window from 0.
- A bit that toggles continuously with a period below `STABLE_CYCLES` never updates `sw`.
- Holding `flag_clr` high keeps `change_flag` at 0, except in cycles where a set is pending, since set has priority.
- The block has no combinational input-to-output path.

## Test plan
All scenarios use `STABLE_CYCLES`=4.
- Reset: assert `rst` for 3 cycles with `sw_raw`=24'hFFFFFF -> `sw`=0, `sw_changed`=0, `change_flag`=0 during reset. After release, `sw` becomes 24'hFFFFFF after edge 5 and `sw_changed` pulses once.
- Clean press: `sw_raw[0]` goes 0->1 before edge 0 and is held -> `sw`=24'h000001 after edge 5. `sw_changed` is 1 for exactly one cycle. `change_flag`=1 and stays 1.
- Bounce: `sw_raw[3]` high for 3 cycles, low for 1, then high and held -> no update until the 4-cycle window completes after the last low. `sw[3]`=1 exactly 5 edges after the final rising sample.
- Short glitch: `sw_raw[7]` high for 2 cycles then low -> `sw` stays 0, `sw_changed` is never asserted, and `cnt[7]` returns to 0.
- Simultaneous and independent bits:
  - `sw_raw` 0 -> 24'hA5A5A5 in one cycle -> all bits update on the same edge and `sw_changed` pulses exactly once.
  - Bits staggered by 2 cycles -> two separate pulses.
- Flag clear race: pulse `flag_clr` on the same edge a bit update occurs -> `change_flag` stays 1. Then pulse `flag_clr` with no update -> `change_flag`=0. Assert `rst` mid-count -> the count is aborted and `sw` holds 0.
